mult_share_arbiter: RTL and testbench

Round-robin scheduler sharing one shift-based multiplier engine (datapath plus its start/done controller) among N requesters. It captures the winning requester's operands, pulses the engine start, and waits for engine done or a watchdog timeout. It then returns the result or an error to that requester. It sits between the requester ports and the single engine instance.

---
 rtl/mult_pkg.sv | 42 ++++
 rtl/mult_share_arbiter_rr_picker.sv | 40 ++++
 rtl/mult_share_arbiter.sv | 156 +++++++++++++++
 tb/tb_mult_share_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_pkg
// Description : Shared definitions for the multiplier-sharing arbiter.
//               Holds the FSM state encoding, default datapath widths and
//               the index-width helper.
//               Contents:
//                 state_e    - IDLE=0, LAUNCH=1, WAIT=2, RESP=3
//                 DATA_W_DEF - default operand width
//                 RES_W_DEF  - default result width (2*DATA_W_DEF)
//                 clog2()    - ceil(log2(value)), returns 0 for value <= 1
//                 idx_w()    - width of a requester index (at least 1)
// Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_e;

    localparam int DATA_W_DEF = 8;
    localparam int RES_W_DEF  = 16;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // A single-requester build would otherwise produce a zero-width index.
    function automatic int idx_w(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mult_share_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : rr_picker
// Description : Combinational round-robin search. Scans the request vector
//               starting at ptr_i and wrapping past the top index; reports
//               whether any request is present and the first one found.
//               Ports:
//                 req_i   [N_REQ]  request levels
//                 ptr_i   [IDX_W]  highest-priority index this round
//                 found_o [1]      at least one request is present
//                 idx_o   [IDX_W]  winning requester index
// Revision    : 1.0 - initial release
// ============================================================================
module rr_picker
    import mult_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    // Walk from the farthest candidate back towards ptr so that the
    // candidate closest to ptr is the last one written and therefore wins.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_i[(int'(ptr_i) + k) % N_REQ]) begin
                found_o = 1'b1;
                idx_o   = IDX_W'((int'(ptr_i) + k) % N_REQ);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mult_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mult_share_arbiter
// Description : Round-robin scheduler sharing one multiplier engine among
//               N_REQ requesters. Captures the winner's operands, pulses the
//               engine start, waits for done or a watchdog timeout and
//               returns the product (or a timeout error) to the winner.
//               Ports:
//                 clk        in   clock, rising edge
//                 rst        in   asynchronous reset, active low
//                 req        in   [N_REQ]          request levels
//                 a_in/b_in  in   [N_REQ*DATA_W]   operand slices
//                 gnt        out  [N_REQ]          one-hot grant pulse
//                 rsp_valid  out  [N_REQ]          one-hot response pulse
//                 rsp_err    out  response is a timeout
//                 rsp_data   out  [RES_W]          response product
//                 eng_start  out  engine start pulse
//                 eng_a/b    out  [DATA_W]         engine operands
//                 eng_done   in   engine done pulse
//                 eng_result in   [RES_W]          engine product
//                 busy       out  high outside IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module mult_share_arbiter
    import mult_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int RES_W   = RES_W_DEF,
    parameter int TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   a_in,
    input  logic [N_REQ*DATA_W-1:0]   b_in,
    output logic [N_REQ-1:0]          gnt,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic                      rsp_err,
    output logic [RES_W-1:0]          rsp_data,
    output logic                      eng_start,
    output logic [DATA_W-1:0]         eng_a,
    output logic [DATA_W-1:0]         eng_b,
    input  logic                      eng_done,
    input  logic [RES_W-1:0]          eng_result,
    output logic                      busy
);

    localparam int IDX_W = idx_w(N_REQ);
    // Counter must reach TIMEOUT-1.
    localparam int CNT_W = clog2(TIMEOUT);

    localparam logic [N_REQ-1:0] ONE_HOT_0 = N_REQ'(1);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q,   idx_d;
    logic [IDX_W-1:0]    ptr_q,   ptr_d;
    logic [DATA_W-1:0]   a_q,     a_d;
    logic [DATA_W-1:0]   b_q,     b_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic [RES_W-1:0]    res_q,   res_d;
    logic                err_q,   err_d;

    logic                pick_found;
    logic [IDX_W-1:0]    pick_idx;

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    idx_d   = pick_idx;
                    a_d     = a_in[int'(pick_idx) * DATA_W +: DATA_W];
                    b_d     = b_in[int'(pick_idx) * DATA_W +: DATA_W];
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // A done arriving in the timeout cycle still counts as success.
                if (eng_done) begin
                    res_d   = eng_result;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                ptr_d   = (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ptr_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    // Every output is a register or a decode of registers, so reset clears
    // all of them without waiting for a clock edge.
    assign gnt       = (state_q == LAUNCH) ? (ONE_HOT_0 << idx_q) : '0;
    assign rsp_valid = (state_q == RESP)   ? (ONE_HOT_0 << idx_q) : '0;
    assign eng_start = (state_q == LAUNCH);
    assign busy      = (state_q != IDLE);
    assign rsp_data  = res_q;
    assign rsp_err   = err_q;
    assign eng_a     = a_q;
    assign eng_b     = b_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_share_arbiter
// Description : Self-checking bench for mult_share_arbiter. A behavioural
//               engine answers a configurable number of cycles after start;
//               expected grants come from a round-robin pointer model and
//               expected results from plain multiplication.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_share_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int RW = 16;
    localparam int TO = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*DW-1:0] a_in;
    logic [N*DW-1:0] b_in;
    logic [N-1:0]    gnt;
    logic [N-1:0]    rsp_valid;
    logic            rsp_err;
    logic [RW-1:0]   rsp_data;
    logic            eng_start;
    logic [DW-1:0]   eng_a;
    logic [DW-1:0]   eng_b;
    logic            eng_done = 1'b0;
    logic [RW-1:0]   eng_result = '0;
    logic            busy;

    int checks = 0;
    int errors = 0;
    int mptr   = 0;

    // Engine model controls: latency 0 means the engine never answers.
    int            eng_lat = 0;
    int            eng_cd  = 0;
    logic [RW-1:0] eng_prod = '0;
    bit            spur = 1'b0;

    mult_share_arbiter #(
        .N_REQ   (N),
        .DATA_W  (DW),
        .RES_W   (RW),
        .TIMEOUT (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .a_in       (a_in),
        .b_in       (b_in),
        .gnt        (gnt),
        .rsp_valid  (rsp_valid),
        .rsp_err    (rsp_err),
        .rsp_data   (rsp_data),
        .eng_start  (eng_start),
        .eng_a      (eng_a),
        .eng_b      (eng_b),
        .eng_done   (eng_done),
        .eng_result (eng_result),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Engine: done pulses eng_lat cycles after the start cycle.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            eng_cd   = 0;
            eng_done = 1'b0;
        end else begin
            #2;
            eng_done = 1'b0;
            if (eng_cd > 0) begin
                eng_cd = eng_cd - 1;
                if (eng_cd == 0) begin
                    eng_done   = 1'b1;
                    eng_result = eng_prod;
                end
            end
            if (eng_start && eng_lat > 0) begin
                eng_cd   = eng_lat;
                eng_prod = RW'(eng_a) * RW'(eng_b);
            end
            if (spur) begin
                eng_done   = 1'b1;
                eng_result = 16'hBEEF;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_gnt"},       32'(gnt),       32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_err"},   32'(rsp_err),   32'd0);
        chk({tag, "_rsp_data"},  32'(rsp_data),  32'd0);
        chk({tag, "_eng_start"}, 32'(eng_start), 32'd0);
        chk({tag, "_eng_a"},     32'(eng_a),     32'd0);
        chk({tag, "_eng_b"},     32'(eng_b),     32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd0);
    endtask

    task automatic set_ops(input int i, input int a, input int b);
        a_in[i*DW +: DW] = DW'(a);
        b_in[i*DW +: DW] = DW'(b);
    endtask

    task automatic rand_ops(input int i);
        set_ops(i, int'($urandom_range(1, 255)), int'($urandom_range(1, 255)));
    endtask

    // One full transaction starting in an IDLE cycle with req already set.
    // Ends in the IDLE cycle after the response.
    task automatic txn(input int lat, input bit rereq);
        int w;
        int ea, eb, n, en, er, ed;
        w = -1;
        for (int k = 0; k < N; k++) begin
            if (w < 0 && req[(mptr + k) % N]) w = (mptr + k) % N;
        end
        if (w < 0) begin
            chk("txn_has_request", 32'(req), 32'd1);
            return;
        end
        ea = int'(a_in[w*DW +: DW]);
        eb = int'(b_in[w*DW +: DW]);
        eng_lat = lat;
        tick();
        chk("gnt",       32'(gnt),       32'(1 << w));
        chk("eng_start", 32'(eng_start), 32'd1);
        chk("eng_a",     32'(eng_a),     32'(ea));
        chk("eng_b",     32'(eng_b),     32'(eb));
        chk("busy_hi",   32'(busy),      32'd1);
        // Requester drops req at grant and is then free to change operands.
        req[w] = 1'b0;
        rand_ops(w);
        n = 0;
        do begin
            tick();
            n++;
        end while (rsp_valid == '0 && n < TO + 20);
        if (lat > 0 && lat <= TO) begin
            en = lat + 1; er = 0; ed = ea * eb;
        end else begin
            en = TO + 1;  er = 1; ed = 0;
        end
        chk("rsp_valid",   32'(rsp_valid), 32'(1 << w));
        chk("rsp_latency", 32'(n),         32'(en));
        chk("rsp_err",     32'(rsp_err),   32'(er));
        chk("rsp_data",    32'(rsp_data),  32'(ed));
        mptr = (w + 1) % N;
        tick();
        chk("busy_idle",     32'(busy),      32'd0);
        chk("rsp_valid_off", 32'(rsp_valid), 32'd0);
        if (rereq) begin
            rand_ops(w);
            req[w] = 1'b1;
        end
    endtask

    initial begin
        int seen;
        rst  = 1'b0;
        req  = '0;
        a_in = '0;
        b_in = '0;
        #1;
        chk_zero("reset");
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Single request from requester 2.
        set_ops(2, 13, 11);
        req[2] = 1'b1;
        txn(10, 1'b0);

        // Wrap-around: pointer now 3, requesters 0 and 1 pending.
        rand_ops(0);
        rand_ops(1);
        req = 4'b0011;
        txn(5, 1'b0);
        txn(7, 1'b0);

        // Timeout, then a normal transaction.
        rand_ops(3);
        req = 4'b1000;
        txn(0, 1'b0);
        rand_ops(1);
        req = 4'b0010;
        txn(int'($urandom_range(1, 20)), 1'b0);

        // Done arriving in the same cycle the watchdog expires.
        rand_ops(2);
        req = 4'b0100;
        txn(TO, 1'b0);

        // Spurious done while idle.
        req  = '0;
        spur = 1'b1;
        tick();
        spur = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("spurious_no_rsp", 32'(rsp_valid), 32'd0);
        end

        // Reset mid-WAIT, three cycles after start.
        rand_ops(1);
        req[1]  = 1'b1;
        eng_lat = 20;
        tick();
        chk("rst_test_gnt", 32'(gnt), 32'b0010);
        req = '0;
        repeat (3) tick();
        chk("rst_test_busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk_zero("async_reset");
        tick();
        tick();
        rst = 1'b1;
        mptr = 0;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (rsp_valid != '0) seen++;
        end
        chk("no_rsp_after_reset", 32'(seen), 32'd0);

        // Fairness with continuous re-requests; pointer restarts at 0.
        for (int i = 0; i < N; i++) rand_ops(i);
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            txn(int'($urandom_range(1, 8)), 1'b1);
        end
        req = '0;
        tick();

        // Randomized traffic.
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < N; j++) rand_ops(j);
            req = N'($urandom_range(1, 15));
            txn(($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 24)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
